tdc_therm_encoder: RTL and testbench
====================================

# tdc_therm_encoder

Consumes the thermometer word captured by the TDC delay line and turns it into timing statistics. Each accepted sample goes through bubble correction and a leading-edge priority encode, then is accumulated over a batch of 2^ACC_LOG2 samples. The block sits directly downstream of the delay-line capture register and presents per-batch mean/min/max plus error flags to the readout logic over a valid/ready handshake.

## Interface
- N_DELAY, 32, thermometer width (delay stages)
- ACC_LOG2, 4, log2 of samples per batch (1..8)
- CNT_W, $clog2(N_DELAY+1), encoded code width (derived, not overridden)

Ports:
- clk  in  1  system clock; the block uses one clock
- rst_n  in  1  asynchronous active-low reset
- therm_in  in  N_DELAY  captured thermometer word, bit0 = first stage; stable while in_valid=1
- in_valid  in  1  therm_in holds a new sample
- in_ready  out  1  block accepts a sample this cycle
- clr  in  1  synchronous batch abort/clear
- out_valid  out  1  batch result available
- out_ready  in  1  consumer takes the result
- out_mean  out  CNT_W  floor(sum of codes / 2^ACC_LOG2)
- out_min  out  CNT_W  minimum code in batch
- out_max  out  CNT_W  maximum code in batch
- out_sat  out  1  a sample in the batch encoded to N_DELAY (all ones)
- out_bubble  out  1  a sample in the batch needed bubble correction

## Operation
- Accept: a sample is accepted on a rising edge where in_valid & in_ready.
- Correction: raw r, corrected c[i] = maj(r[i-1], r[i], r[i+1]), with r[-1]=1 and r[N_DELAY]=0.
- Bubble flag: per-sample bubble = (c != r).
- Encode: code = index of the lowest zero in c, or N_DELAY if c is all ones. sat = (code == N_DELAY).
- Pipeline:
  - S1 registers therm_in.
  - S2 registers code, sat and bubble.
  - S3 updates the accumulator and stats.
- Statistics: accumulator width CNT_W+ACC_LOG2 and never overflows. min, max, sat_any and bubble_any are updated per sample.
- Batch counter: counts accepted samples, 0..2^ACC_LOG2.
- FSM:
  - ACCUM: in_ready=1. On the accept that makes the count 2^ACC_LOG2, go to DRAIN.
  - DRAIN: in_ready=0. When the last sample is accumulated in S3, go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready, clear acc/count/flags, set min to all ones and max to 0, and go to ACCUM.
- out_mean = acc >> ACC_LOG2, a pure wire shift of the register.
- clr (highest synchronous priority):
  - Empties S1/S2 valid bits and resets acc, count, min, max and flags.
  - FSM goes to ACCUM and out_valid drops next edge.
  - A sample offered in the same cycle is dropped.
- Reset: rst_n low clears everything asynchronously.
  - FSM goes to ACCUM; reset values: in_ready=1, out_valid=0, out_mean/out_min/out_max=0, out_sat/out_bubble=0.
  - min is internally reloaded to all ones at batch start.

## Timing
- Sample accepted at edge E: encoded at E+1, accumulated at E+2.
- Last sample of a batch accepted at E: out_valid=1 is visible after E+2. In_ready is 0 from E+1 until the cycle after the out handshake.
- out_valid and all out_* stay stable until the handshake; out_ready is ignored when out_valid=0.
- In DONE, simultaneous in_valid and out_ready: the sample is not accepted that cycle. in_ready=1 on the next cycle.
- Throughput: one sample per cycle while in ACCUM.

## Structure
- Package tdc_pkg holds:
  - the FSM state enum (ACCUM, DRAIN, DONE);
  - the CNT_W computation function;
  - the majority helper.
- One combinational sub-module, tdc_therm2bin: therm → (code, sat, bubble), parameterised by N_DELAY. It is instantiated at S1→S2.
- FSM, counters and accumulator live in tdc_therm_encoder.

## Test plan
All scenarios use N_DELAY=32, ACC_LOG2=2.
- Four samples 0x0000000F, 0x0000001F ×3, back-to-back → out_mean=4 (19>>2), min=4, max=5, sat=0, bubble=0; out_valid 2 edges after the 4th accept.
- Bubble sample 0x000000F7, then 0x00000002 → codes 8 and 1, out_bubble=1. Fill the batch with 0x000000FF ×2 → mean 6 (25>>2), min 1, max 8.
- Samples 0x00000000, 0xFFFFFFFF, 0x000000FF, 0x000000FF → mean 12, min 0, max 32, out_sat=1.
- Hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, no sample accepted. Then out_ready=1 → in_ready=1 next cycle and the next batch starts clean.
- clr after 2 accepted samples of 0xFFFFFFFF, with a sample offered the same cycle → that sample is dropped. Then 4×0x0000000F → mean 4, max 4, sat 0.
- rst_n pulsed low during DRAIN → immediately out_valid=0, in_ready=1, all outputs 0. After release, a fresh 4-sample batch produces the correct result.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC thermometer encoder.
package tdc_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } tdc_state_e;

   function automatic int unsigned cnt_width(input int unsigned n_delay);
      return $clog2(n_delay + 1);
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// Bubble-corrects a thermometer word and encodes its leading edge.
module tdc_therm2bin
   import tdc_pkg::*;
#(
   parameter  int unsigned N_DELAY = 32,
   localparam int unsigned CNT_W   = cnt_width(N_DELAY)
) (
   input  logic [N_DELAY-1:0] therm,
   output logic [CNT_W-1:0]   code_c,
   output logic               sat_c,
   output logic               bubble_c
);

   logic [N_DELAY+1:0] ext;
   logic [N_DELAY-1:0] corr;

   // Stage below the first is treated as fired, stage past the last as not.
   assign ext = {1'b0, therm, 1'b1};

   for (genvar i = 0; i < N_DELAY; i++) begin : g_maj
      assign corr[i] = maj3(ext[i], ext[i+1], ext[i+2]);
   end

   // Lowest zero wins; all ones encodes to N_DELAY.
   always_comb begin
      code_c = CNT_W'(N_DELAY);
      for (int i = int'(N_DELAY) - 1; i >= 0; i--) begin
         if (!corr[i]) code_c = CNT_W'(i);
      end
   end

   assign sat_c    = (code_c == CNT_W'(N_DELAY));
   assign bubble_c = (corr != therm);

endmodule

// File: rtl/tdc_therm_encoder.sv
// Encodes TDC thermometer samples and reports per-batch mean/min/max and flags.
module tdc_therm_encoder
   import tdc_pkg::*;
#(
   parameter  int unsigned N_DELAY  = 32,
   parameter  int unsigned ACC_LOG2 = 4,
   localparam int unsigned CNT_W    = cnt_width(N_DELAY)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_DELAY-1:0] therm_in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               clr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CNT_W-1:0]   out_mean,
   output logic [CNT_W-1:0]   out_min,
   output logic [CNT_W-1:0]   out_max,
   output logic               out_sat,
   output logic               out_bubble
);

   localparam int unsigned       ACC_W    = CNT_W + ACC_LOG2;
   localparam int unsigned       BCNT_W   = ACC_LOG2 + 1;
   localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'((1 << ACC_LOG2) - 1);
   localparam logic [CNT_W-1:0]  MIN_INIT = '1;

   tdc_state_e         state;
   logic               s1_valid;
   logic [N_DELAY-1:0] s1_therm;
   logic               s2_valid;
   logic [CNT_W-1:0]   s2_code;
   logic               s2_sat;
   logic               s2_bubble;
   logic [ACC_W-1:0]   acc;
   logic [BCNT_W-1:0]  batch_cnt;
   logic               first_smp;
   logic [CNT_W-1:0]   enc_code;
   logic               enc_sat;
   logic               enc_bubble;
   logic               accept;

   assign accept   = in_valid & in_ready & ~clr;
   assign out_mean = CNT_W'(acc >> ACC_LOG2);

   tdc_therm2bin #(
      .N_DELAY (N_DELAY)
   ) u_therm2bin (
      .therm    (s1_therm),
      .code_c   (enc_code),
      .sat_c    (enc_sat),
      .bubble_c (enc_bubble)
   );

   // Pipeline, statistics and batch FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ACCUM;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         s1_valid   <= 1'b0;
         s1_therm   <= '0;
         s2_valid   <= 1'b0;
         s2_code    <= '0;
         s2_sat     <= 1'b0;
         s2_bubble  <= 1'b0;
         acc        <= '0;
         batch_cnt  <= '0;
         first_smp  <= 1'b1;
         out_min    <= '0;
         out_max    <= '0;
         out_sat    <= 1'b0;
         out_bubble <= 1'b0;
      end else if (clr) begin
         state      <= ACCUM;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         acc        <= '0;
         batch_cnt  <= '0;
         first_smp  <= 1'b1;
         out_min    <= MIN_INIT;
         out_max    <= '0;
         out_sat    <= 1'b0;
         out_bubble <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) s1_therm <= therm_in;

         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_code   <= enc_code;
            s2_sat    <= enc_sat;
            s2_bubble <= enc_bubble;
         end

         // The first sample of a batch seeds min regardless of its reload value.
         if (s2_valid) begin
            acc        <= acc + ACC_W'(s2_code);
            out_min    <= (first_smp || (s2_code < out_min)) ? s2_code : out_min;
            out_max    <= (s2_code > out_max) ? s2_code : out_max;
            out_sat    <= out_sat | s2_sat;
            out_bubble <= out_bubble | s2_bubble;
            first_smp  <= 1'b0;
         end

         unique case (state)
            ACCUM: begin
               if (accept) begin
                  batch_cnt <= batch_cnt + BCNT_W'(1);
                  if (batch_cnt == LAST_IDX) begin
                     state    <= DRAIN;
                     in_ready <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               // No accepts in DRAIN, so an empty S1 means S2 holds the last sample.
               if (s2_valid && !s1_valid) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state      <= ACCUM;
                  in_ready   <= 1'b1;
                  out_valid  <= 1'b0;
                  acc        <= '0;
                  batch_cnt  <= '0;
                  first_smp  <= 1'b1;
                  out_min    <= MIN_INIT;
                  out_max    <= '0;
                  out_sat    <= 1'b0;
                  out_bubble <= 1'b0;
               end
            end
            default: begin
               state    <= ACCUM;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdc_therm_encoder.sv
// Self-checking bench for tdc_therm_encoder with N_DELAY=32, ACC_LOG2=2.
module tb_tdc_therm_encoder;

   localparam int unsigned N_DELAY  = 32;
   localparam int unsigned ACC_LOG2 = 2;
   localparam int unsigned CNT_W    = 6;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N_DELAY-1:0] therm_in;
   logic               in_valid;
   logic               in_ready;
   logic               clr;
   logic               out_valid;
   logic               out_ready;
   logic [CNT_W-1:0]   out_mean;
   logic [CNT_W-1:0]   out_min;
   logic [CNT_W-1:0]   out_max;
   logic               out_sat;
   logic               out_bubble;

   int total = 0;
   int bad   = 0;
   logic [31:0] model_q[$];

   tdc_therm_encoder #(
      .N_DELAY  (N_DELAY),
      .ACC_LOG2 (ACC_LOG2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .therm_in   (therm_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .clr        (clr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_mean   (out_mean),
      .out_min    (out_min),
      .out_max    (out_max),
      .out_sat    (out_sat),
      .out_bubble (out_bubble)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference: majority vote over neighbours, then first zero from the bottom.
   function automatic int ref_code(input logic [31:0] r, output bit bub);
      int ext[34];
      bit [31:0] c;
      int code;
      ext[0]  = 1;
      ext[33] = 0;
      for (int k = 0; k < 32; k++) ext[k+1] = r[k] ? 1 : 0;
      for (int k = 0; k < 32; k++) c[k] = (ext[k] + ext[k+1] + ext[k+2]) >= 2;
      bub  = (c != r);
      code = 0;
      while (code < 32 && c[code]) code++;
      return code;
   endfunction

   function automatic logic [31:0] rand_therm();
      int k;
      logic [31:0] w;
      logic [31:0] one = 32'd1;
      k = int'($urandom_range(0, 32));
      w = (k == 32) ? 32'hFFFF_FFFF : ((one << k) - 32'd1);
      if ($urandom_range(0, 3) == 0) w = w ^ (one << $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) w = $urandom;
      return w;
   endfunction

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic push(input logic [31:0] w);
      int n = 0;
      therm_in = w;
      in_valid = 1'b1;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("push_ready", in_ready, 1);
      if (in_ready) model_q.push_back(w);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic finish_batch(input int hold);
      int sum = 0, mn = 1000, mx = -1, code, n = 0;
      bit sat = 0, bub = 0, b;
      foreach (model_q[k]) begin
         code = ref_code(model_q[k], b);
         sum += code;
         if (code < mn) mn = code;
         if (code > mx) mx = code;
         if (code == 32) sat = 1;
         if (b) bub = 1;
      end
      check("batch_size", model_q.size(), 4);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_seen", out_valid, 1);
      check("mean", out_mean, sum / 4);
      check("min", out_min, mn);
      check("max", out_max, mx);
      check("sat", out_sat, sat);
      check("bubble", out_bubble, bub);
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_mean", out_mean, sum / 4);
         check("hold_min", out_min, mn);
         check("hold_max", out_max, mx);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_hs_valid", out_valid, 0);
      check("post_hs_in_ready", in_ready, 1);
      model_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      therm_in  = '0;
      in_valid  = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_mean", out_mean, 0);
      check("rst_min", out_min, 0);
      check("rst_max", out_max, 0);
      check("rst_sat", out_sat, 0);
      check("rst_bubble", out_bubble, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back batch with latency check.
      push(32'h0000_000F);
      push(32'h0000_001F);
      push(32'h0000_001F);
      push(32'h0000_001F);
      check("lat_in_ready_e0", in_ready, 0);
      check("lat_valid_e0", out_valid, 0);
      @(negedge clk);
      check("lat_valid_e1", out_valid, 0);
      @(negedge clk);
      check("lat_valid_e2", out_valid, 1);
      check("dir1_mean", out_mean, 4);
      finish_batch(0);

      // Bubble batch.
      push(32'h0000_00F7);
      push(32'h0000_0002);
      push(32'h0000_00FF);
      push(32'h0000_00FF);
      check("dir2_mean", 32'(out_valid), 0);
      finish_batch(0);

      // Saturation batch, held with a sample offered during DONE.
      push(32'h0000_0000);
      push(32'hFFFF_FFFF);
      push(32'h0000_00FF);
      push(32'h0000_00FF);
      therm_in = 32'h0000_000F;
      in_valid = 1'b1;
      finish_batch(10);
      for (int s = 0; s < 4; s++) push(32'h0000_000F);
      finish_batch(0);

      // Clear mid-batch drops pipeline and the sample offered with clr.
      push(32'hFFFF_FFFF);
      push(32'hFFFF_FFFF);
      therm_in = 32'h0000_0001;
      in_valid = 1'b1;
      clr      = 1'b1;
      @(negedge clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      model_q.delete();
      check("clr_out_valid", out_valid, 0);
      check("clr_in_ready", in_ready, 1);
      for (int s = 0; s < 4; s++) push(32'h0000_000F);
      finish_batch(0);

      // Reset during DRAIN.
      for (int s = 0; s < 4; s++) push(32'h0000_00FF);
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_mean", out_mean, 0);
      check("arst_min", out_min, 0);
      check("arst_max", out_max, 0);
      check("arst_sat", out_sat, 0);
      check("arst_bubble", out_bubble, 0);
      model_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(32'h0000_0003);
      push(32'h0000_0007);
      push(32'h0000_000F);
      push(32'h0000_001F);
      finish_batch(0);

      // Randomised batches with idle gaps and consumer stalls.
      for (int b = 0; b < 8; b++) begin
         for (int s = 0; s < 4; s++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push(rand_therm());
         end
         finish_batch(int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
